// File: rtl/hazard_sb.sv
// Pipeline hazard unit with multi-stage forwarding, long-latency scoreboard
// and deferred exception flush while the memory interface is stalling.
module hazard_sb #(
   parameter int unsigned REG_W      = 5,
   parameter int unsigned NREG       = 32,
   parameter int unsigned FWD_STAGES = 2,
   parameter int unsigned SEL_W      = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
   parameter logic [31:0] ERET_CODE  = 32'h0000000E
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [REG_W-1:0]               rsD,
   input  logic [REG_W-1:0]               rtD,
   input  logic [REG_W-1:0]               wregD,
   input  logic                           branchD,
   input  logic                           jrD,
   input  logic                           longopD,
   input  logic [REG_W-1:0]               rsE,
   input  logic [REG_W-1:0]               rtE,
   input  logic [REG_W-1:0]               writeregE,
   input  logic                           regwriteE,
   input  logic                           memtoregE,
   input  logic                           issueE,
   input  logic [FWD_STAGES*REG_W-1:0]    writereg_stg,
   input  logic [FWD_STAGES-1:0]          regwrite_stg,
   input  logic                           memtoregM,
   input  logic                           wb_long_valid,
   input  logic [REG_W-1:0]               wb_long_reg,
   input  logic                           mem_stall,
   input  logic [31:0]                    excepttypeM,
   input  logic [31:0]                    epc_o,
   output logic                           forwardaD,
   output logic                           forwardbD,
   output logic [SEL_W-1:0]               forwardaE,
   output logic [SEL_W-1:0]               forwardbE,
   output logic                           stallF,
   output logic                           stallD,
   output logic                           stallE,
   output logic                           stallM,
   output logic                           stallW,
   output logic                           flushF,
   output logic                           flushD,
   output logic                           flushE,
   output logic                           flushM,
   output logic                           flushW,
   output logic                           flush_except,
   output logic [31:0]                    pcnewM,
   output logic [NREG-1:0]                sb_busy
);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [NREG-1:0]   sb_q, sb_d;

   logic              exc;
   logic [31:0]       pc_sel;
   logic              exc_flush;
   logic [31:0]       exc_pc;

   logic [REG_W-1:0]  dst0;
   logic              rs_e_hit, rt_e_hit;
   logic              rs_m_hit, rt_m_hit;
   logic              lw_hzd, br_hzd, jr_hzd, sb_hzd, hzd;
   logic [4:0]        stall_v, flush_v;

   assign dst0   = writereg_stg[REG_W-1:0];
   assign exc    = |excepttypeM;
   assign pc_sel = (excepttypeM == ERET_CODE) ? epc_o : EXC_VECTOR;

   // Execute-stage forwarding: lowest-index (youngest) matching stage wins.
   always_comb begin
      forwardaE = '0;
      forwardbE = '0;
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
         if (regwrite_stg[k] && rsE != '0 &&
             writereg_stg[k*REG_W +: REG_W] == rsE)
            forwardaE = SEL_W'(k + 1);
         if (regwrite_stg[k] && rtE != '0 &&
             writereg_stg[k*REG_W +: REG_W] == rtE)
            forwardbE = SEL_W'(k + 1);
      end
   end

   // Decode-stage forwarding of the M result into the branch comparator.
   always_comb begin
      forwardaD = regwrite_stg[0] && rsD != '0 && rsD == dst0;
      forwardbD = regwrite_stg[0] && rtD != '0 && rtD == dst0;
   end

   // Hazard terms; register 0 never matches.
   always_comb begin
      rs_e_hit = rsD != '0 && rsD == writeregE;
      rt_e_hit = rtD != '0 && rtD == writeregE;
      rs_m_hit = rsD != '0 && rsD == dst0;
      rt_m_hit = rtD != '0 && rtD == dst0;
      lw_hzd = memtoregE && (rs_e_hit || rt_e_hit);
      br_hzd = branchD &&
               ((regwriteE && (rs_e_hit || rt_e_hit)) ||
                (memtoregM && (rs_m_hit || rt_m_hit)));
      jr_hzd = jrD &&
               ((regwriteE && rs_e_hit) || (memtoregM && rs_m_hit));
      sb_hzd = sb_q[rsD] || sb_q[rtD] || (longopD && sb_q[wregD]);
      hzd    = lw_hzd || br_hzd || jr_hzd || sb_hzd;
   end

   // Exception FSM: flush at once, or defer until mem_stall drops.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      exc_flush = 1'b0;
      exc_pc    = '0;
      unique case (state_q)
         RUN: begin
            if (exc && mem_stall) begin
               state_d = PEND;
               pc_d    = pc_sel;
            end else if (exc) begin
               exc_flush = 1'b1;
               exc_pc    = pc_sel;
            end
         end
         PEND: begin
            if (!mem_stall) begin
               exc_flush = 1'b1;
               exc_pc    = pc_q;
               state_d   = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      if (rst) begin
         exc_flush = 1'b0;
         exc_pc    = '0;
      end
   end

   // Scoreboard next state: an issue overrides a same-cycle completion.
   always_comb begin
      sb_d = sb_q;
      if (wb_long_valid)
         sb_d[wb_long_reg] = 1'b0;
      if (issueE && !exc_flush && writeregE != '0)
         sb_d[writeregE] = 1'b1;
      sb_d[0] = 1'b0;
   end

   // Stall/flush resolution in priority order.
   always_comb begin
      stall_v = 5'b00000;
      flush_v = 5'b00000;
      priority case (1'b1)
         rst: begin
            stall_v = 5'b00000;
         end
         exc_flush: begin
            flush_v = 5'b11111;
         end
         (mem_stall || state_q == PEND): begin
            stall_v = 5'b11111;
         end
         hzd: begin
            stall_v = 5'b11000;
            flush_v = 5'b00100;
         end
         default: begin
            stall_v = 5'b00000;
         end
      endcase
   end

   // State, latched redirect PC and scoreboard registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= '0;
         sb_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sb_q    <= sb_d;
      end
   end

   assign {stallF, stallD, stallE, stallM, stallW} = stall_v;
   assign {flushF, flushD, flushE, flushM, flushW} = flush_v;
   assign flush_except = exc_flush;
   assign pcnewM       = exc_pc;
   assign sb_busy      = sb_q;

endmodule

// File: tb/tb_hazard_sb.sv
// Randomised and directed bench for hazard_sb against a behavioural model
// of forwarding, scoreboard and deferred-exception rules.
module tb_hazard_sb;

   localparam int FS = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rsD, rtD, wregD, rsE, rtE, writeregE, wb_long_reg;
   logic        branchD, jrD, longopD, regwriteE, memtoregE, issueE;
   logic        memtoregM, wb_long_valid, mem_stall;
   logic [4:0]  wr [FS];
   logic [FS-1:0]   regwrite_stg;
   logic [FS*5-1:0] writereg_stg;
   logic [31:0] excepttypeM, epc_o;

   logic        forwardaD, forwardbD;
   logic [1:0]  forwardaE, forwardbE;
   logic        stallF, stallD, stallE, stallM, stallW;
   logic        flushF, flushD, flushE, flushM, flushW;
   logic        flush_except;
   logic [31:0] pcnewM;
   logic [31:0] sb_busy;

   always #5 clk = ~clk;

   always_comb begin
      writereg_stg = '0;
      for (int k = 0; k < FS; k++)
         writereg_stg[k*5 +: 5] = wr[k];
   end

   hazard_sb #(.FWD_STAGES(FS), .SEL_W(2)) dut (
      .clk(clk), .rst(rst),
      .rsD(rsD), .rtD(rtD), .wregD(wregD),
      .branchD(branchD), .jrD(jrD), .longopD(longopD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
      .regwriteE(regwriteE), .memtoregE(memtoregE), .issueE(issueE),
      .writereg_stg(writereg_stg), .regwrite_stg(regwrite_stg),
      .memtoregM(memtoregM),
      .wb_long_valid(wb_long_valid), .wb_long_reg(wb_long_reg),
      .mem_stall(mem_stall), .excepttypeM(excepttypeM), .epc_o(epc_o),
      .forwardaD(forwardaD), .forwardbD(forwardbD),
      .forwardaE(forwardaE), .forwardbE(forwardbE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE),
      .stallM(stallM), .stallW(stallW),
      .flushF(flushF), .flushD(flushD), .flushE(flushE),
      .flushM(flushM), .flushW(flushW),
      .flush_except(flush_except), .pcnewM(pcnewM), .sb_busy(sb_busy)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference model state.
   bit [31:0]   m_busy = '0;
   bit          m_pend = 1'b0;
   logic [31:0] m_pc   = '0;

   // Values sampled from the DUT in the last cycle, for directed checks.
   logic [1:0]  s_fa, s_fb;
   logic [4:0]  s_st, s_fl;
   logic        s_fx;
   logic [31:0] s_pc, s_busy;

   function automatic bit eqnz(input logic [4:0] a, input logic [4:0] b);
      return a != 0 && a == b;
   endfunction

   function automatic int fwd_of(input logic [4:0] r);
      if (r == 0) return 0;
      for (int k = 0; k < FS; k++)
         if (regwrite_stg[k] && wr[k] == r) return k + 1;
      return 0;
   endfunction

   task automatic cycle();
      bit          ex, efx, hz, lw, br, jr, sb;
      logic [31:0] pcs, epc;
      logic [4:0]  est, efl;
      #1;
      ex  = excepttypeM != 0;
      pcs = (excepttypeM == 32'h0000000E) ? epc_o : 32'hBFC00380;
      efx = !rst && !mem_stall && (m_pend || ex);
      epc = !efx ? 32'h0 : (m_pend ? m_pc : pcs);
      lw  = memtoregE && (eqnz(rsD, writeregE) || eqnz(rtD, writeregE));
      br  = branchD &&
            ((regwriteE && (eqnz(rsD, writeregE) || eqnz(rtD, writeregE))) ||
             (memtoregM && (eqnz(rsD, wr[0]) || eqnz(rtD, wr[0]))));
      jr  = jrD && ((regwriteE && eqnz(rsD, writeregE)) ||
                    (memtoregM && eqnz(rsD, wr[0])));
      sb  = m_busy[rsD] || m_busy[rtD] || (longopD && m_busy[wregD]);
      hz  = lw || br || jr || sb;
      est = 5'b00000;
      efl = 5'b00000;
      if (rst) ;
      else if (efx) efl = 5'b11111;
      else if (mem_stall || m_pend) est = 5'b11111;
      else if (hz) begin
         est = 5'b11000;
         efl = 5'b00100;
      end
      s_fa   = forwardaE;
      s_fb   = forwardbE;
      s_st   = {stallF, stallD, stallE, stallM, stallW};
      s_fl   = {flushF, flushD, flushE, flushM, flushW};
      s_fx   = flush_except;
      s_pc   = pcnewM;
      s_busy = sb_busy;
      check("fwdaE", 32'(s_fa), 32'(fwd_of(rsE)));
      check("fwdbE", 32'(s_fb), 32'(fwd_of(rtE)));
      check("fwdaD", 32'(forwardaD),
            32'(regwrite_stg[0] && eqnz(rsD, wr[0])));
      check("fwdbD", 32'(forwardbD),
            32'(regwrite_stg[0] && eqnz(rtD, wr[0])));
      check("stall", 32'(s_st), 32'(est));
      check("flush", 32'(s_fl), 32'(efl));
      check("fx", 32'(s_fx), 32'(efx));
      check("pcnew", s_pc, epc);
      check("busy", s_busy, m_busy);
      @(posedge clk);
      if (rst) begin
         m_busy = '0;
         m_pend = 1'b0;
         m_pc   = '0;
      end else begin
         if (wb_long_valid) m_busy[wb_long_reg] = 1'b0;
         if (issueE && !efx && writeregE != 0) m_busy[writeregE] = 1'b1;
         if (!m_pend) begin
            if (ex && mem_stall) begin
               m_pend = 1'b1;
               m_pc   = pcs;
            end
         end else if (!mem_stall) begin
            m_pend = 1'b0;
         end
      end
      #1;
   endtask

   task automatic idle();
      rst = 0;
      rsD = 0; rtD = 0; wregD = 0; rsE = 0; rtE = 0; writeregE = 0;
      branchD = 0; jrD = 0; longopD = 0;
      regwriteE = 0; memtoregE = 0; issueE = 0; memtoregM = 0;
      wb_long_valid = 0; wb_long_reg = 0; mem_stall = 0;
      excepttypeM = 0; epc_o = 0;
      regwrite_stg = '0;
      for (int k = 0; k < FS; k++) wr[k] = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      cycle();
      check("rst_stall", 32'(s_st), 32'h0);
      check("rst_busy", s_busy, 32'h0);
      idle();

      // Forwarding priority.
      rsE = 5; rtE = 5;
      for (int k = 0; k < FS; k++) wr[k] = 5;
      regwrite_stg = 3'b111;
      cycle();
      check("fwd_youngest", 32'(s_fa), 32'd1);
      regwrite_stg = 3'b110;
      cycle();
      check("fwd_stage1", 32'(s_fa), 32'd2);
      rsE = 0;
      cycle();
      check("fwd_r0", 32'(s_fa), 32'd0);
      check("fwd_b_stage1", 32'(s_fb), 32'd2);
      idle();

      // Load-use.
      memtoregE = 1; writeregE = 8; rsD = 8;
      cycle();
      check("lu_stall", 32'(s_st), 32'h18);
      check("lu_flushE", 32'(s_fl), 32'h04);
      idle();
      cycle();
      check("lu_release", 32'(s_st), 32'h0);

      // Scoreboard set, stall, release.
      issueE = 1; writeregE = 9;
      cycle();
      issueE = 0; rtD = 9;
      cycle();
      check("sb_set", 32'(s_busy[9]), 32'd1);
      check("sb_stall", 32'(s_st), 32'h18);
      wb_long_valid = 1; wb_long_reg = 9;
      cycle();
      check("sb_wb_cycle", 32'(s_st), 32'h18);
      wb_long_valid = 0;
      cycle();
      check("sb_released", 32'(s_st), 32'h0);
      check("sb_cleared", 32'(s_busy[9]), 32'd0);
      idle();

      // Same-cycle issue and completion.
      issueE = 1; writeregE = 9;
      cycle();
      wb_long_valid = 1; wb_long_reg = 9;
      cycle();
      idle();
      cycle();
      check("sb_set_wins", 32'(s_busy[9]), 32'd1);
      wb_long_valid = 1; wb_long_reg = 9;
      cycle();
      idle();

      // Immediate exception.
      excepttypeM = 32'h1;
      cycle();
      check("exc_fx", 32'(s_fx), 32'd1);
      check("exc_flush", 32'(s_fl), 32'h1F);
      check("exc_pc", s_pc, 32'hBFC00380);
      idle();

      // Deferred eret.
      excepttypeM = 32'h0000000E; epc_o = 32'h80001234; mem_stall = 1;
      repeat (3) begin
         cycle();
         check("eret_nofx", 32'(s_fx), 32'd0);
         check("eret_stall", 32'(s_st), 32'h1F);
         excepttypeM = 32'h1;
      end
      excepttypeM = 0; epc_o = 0; mem_stall = 0;
      cycle();
      check("eret_fx", 32'(s_fx), 32'd1);
      check("eret_pc", s_pc, 32'h80001234);
      idle();

      // Reset while pending.
      issueE = 1; writeregE = 3;
      cycle();
      idle();
      excepttypeM = 32'h1; mem_stall = 1;
      cycle();
      rst = 1;
      cycle();
      check("rstp_fx", 32'(s_fx), 32'd0);
      idle();
      cycle();
      check("rstp_nofx", 32'(s_fx), 32'd0);
      check("rstp_busy", s_busy, 32'h0);
      check("rstp_stall", 32'(s_st), 32'h0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) < 2);
         rsD = 5'($urandom_range(0, 7));
         rtD = 5'($urandom_range(0, 7));
         wregD = 5'($urandom_range(0, 7));
         rsE = 5'($urandom_range(0, 7));
         rtE = 5'($urandom_range(0, 7));
         writeregE = 5'($urandom_range(0, 7));
         branchD = ($urandom_range(0, 3) == 0);
         jrD = ($urandom_range(0, 5) == 0);
         longopD = ($urandom_range(0, 3) == 0);
         regwriteE = $urandom_range(0, 1);
         memtoregE = ($urandom_range(0, 3) == 0);
         issueE = ($urandom_range(0, 4) == 0);
         memtoregM = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < FS; k++) wr[k] = 5'($urandom_range(0, 7));
         regwrite_stg = 3'($urandom);
         wb_long_valid = ($urandom_range(0, 2) == 0);
         wb_long_reg = 5'($urandom_range(0, 7));
         mem_stall = ($urandom_range(0, 3) == 0);
         epc_o = $urandom;
         case ($urandom_range(0, 19))
            0: excepttypeM = 32'h0000000E;
            1: excepttypeM = 32'($urandom_range(1, 255));
            default: excepttypeM = 0;
         endcase
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
